// File: rtl/prg_pkg.sv
// prg_pkg: shared constants and types for the program register bank.
//   PRG_ADDR_W / PRG_DATA_W : default address and data widths
//   PRG_MODE_ADDR           : register holding the mode bit (written by SWITCH)
//   prg_wr_t                : one write request (flag, addr, data)
//   prg_src_e               : which source the array commits on a given edge
package prg_pkg;

  localparam int PRG_ADDR_W = 8;
  localparam int PRG_DATA_W = 32;
  localparam logic [PRG_ADDR_W-1:0] PRG_MODE_ADDR = 8'h24;

  typedef struct packed {
    logic                  flag;
    logic [PRG_ADDR_W-1:0] addr;
    logic [PRG_DATA_W-1:0] data;
  } prg_wr_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_PEND = 2'd2,
    SRC_PC   = 2'd3
  } prg_src_e;

endpackage

// File: rtl/prg_write_arbiter.sv
// prg_write_arbiter: merges the ALU writeback port and the PC/stack write port
// into one array write per edge, deferring a losing PC/stack write into a
// one-entry pending slot.
// Ports:
//   clock, reset          : clock, async active-high reset
//   alu_flag/addr/data    : ALU writeback request (highest priority)
//   pc_flag/addr/data     : PC/stack write request
//   commit_src            : source committed this edge (NONE/ALU/PEND/PC);
//                           also serves as the observable arbitration state
//   commit_addr/data      : write presented to the array this edge
//   pend_valid/addr/data  : pending slot contents (used for read override)
//   stall                 : slot occupied; PC/stack must not issue
//   drop_err              : sticky, a PC/stack write was lost
// Handshake: the PC/stack port has no ready; it must hold off while stall=1.
// A write issued anyway is merged into the slot when the address matches,
// otherwise it is dropped and drop_err latches.
module prg_write_arbiter
  import prg_pkg::*;
#(
  parameter int ADDR_W = PRG_ADDR_W,
  parameter int DATA_W = PRG_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_flag,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              pc_flag,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] pc_data,
  output prg_src_e          commit_src,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_data,
  output logic              stall,
  output logic              drop_err
);

  logic              pend_valid_n;
  logic [ADDR_W-1:0] pend_addr_n;
  logic [DATA_W-1:0] pend_data_n;
  logic              drop_set;
  logic              pc_collide;

  // Same-cycle ALU write to the PC target: ALU wins, PC value is simply stale.
  assign pc_collide = alu_flag && (alu_addr == pc_addr);
  assign stall      = pend_valid;

  // Commit selection: ALU, then pending slot, then direct PC/stack.
  always_comb begin
    commit_src  = SRC_NONE;
    commit_addr = pc_addr;
    commit_data = pc_data;
    if (alu_flag) begin
      commit_src  = SRC_ALU;
      commit_addr = alu_addr;
      commit_data = alu_data;
    end else if (pend_valid) begin
      commit_src  = SRC_PEND;
      commit_addr = pend_addr;
      commit_data = pend_data;
    end else if (pc_flag) begin
      commit_src  = SRC_PC;
    end
  end

  // Slot update. The "after this edge" view of the slot decides whether an
  // unserviced PC/stack write can be absorbed.
  always_comb begin
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    pend_data_n  = pend_data;
    drop_set     = 1'b0;
    if (commit_src == SRC_PEND) begin
      pend_valid_n = 1'b0;
    end else if (commit_src == SRC_ALU && pend_valid && pend_addr == alu_addr) begin
      // ALU value is newer than the deferred one.
      pend_valid_n = 1'b0;
    end
    if (pc_flag && commit_src != SRC_PC && !pc_collide) begin
      if (!pend_valid_n) begin
        pend_valid_n = 1'b1;
        pend_addr_n  = pc_addr;
        pend_data_n  = pc_data;
      end else if (pend_addr_n == pc_addr) begin
        pend_data_n  = pc_data;
      end else begin
        drop_set     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      drop_err   <= 1'b0;
    end else begin
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
      pend_data  <= pend_data_n;
      if (drop_set) drop_err <= 1'b1;
    end
  end

endmodule

// File: rtl/prg_register_bank.sv
// prg_register_bank: 2^ADDR_W x DATA_W program register array with two write
// sources (ALU writeback, PC/stack) arbitrated by prg_write_arbiter, two
// combinational read ports and the exported mode bit.
// Optional feature macro: PRG_BYPASS_EN -- when defined, reads and mode_flag
// forward the write being committed this cycle (zero-latency visibility).
// Ports:
//   clock, reset                    : clock, async active-high reset
//   PRG_write_flag/addr/data        : PC/stack write port
//   ALU_write_flag/addr/data        : ALU writeback port
//   rd_addr_a/b, rd_data_a/b        : asynchronous read ports
//   mode_flag                       : bit 0 of register MODE_ADDR (slot-aware)
//   stall                           : pending slot occupied
//   drop_err                        : sticky lost-write flag
module prg_register_bank
  import prg_pkg::*;
#(
  parameter int                ADDR_W    = PRG_ADDR_W,
  parameter int                DATA_W    = PRG_DATA_W,
  parameter logic [ADDR_W-1:0] MODE_ADDR = PRG_MODE_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PRG_write_flag,
  input  logic [ADDR_W-1:0] PRG_write_addr,
  input  logic [DATA_W-1:0] PRG_write_data,
  input  logic              ALU_write_flag,
  input  logic [ADDR_W-1:0] ALU_write_addr,
  input  logic [DATA_W-1:0] ALU_write_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              mode_flag,
  output logic              stall,
  output logic              drop_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  prg_src_e          commit_src;
  logic              commit_en;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              fwd_en;

  prg_write_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .alu_flag   (ALU_write_flag),
    .alu_addr   (ALU_write_addr),
    .alu_data   (ALU_write_data),
    .pc_flag    (PRG_write_flag),
    .pc_addr    (PRG_write_addr),
    .pc_data    (PRG_write_data),
    .commit_src (commit_src),
    .commit_addr(commit_addr),
    .commit_data(commit_data),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .stall      (stall),
    .drop_err   (drop_err)
  );

  assign commit_en = (commit_src != SRC_NONE);

`ifdef PRG_BYPASS_EN
  // Held off during reset so reads stay at 0 while reset is asserted.
  assign fwd_en = commit_en && !reset;
`else
  assign fwd_en = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_en) begin
      mem[commit_addr] <= commit_data;
    end
  end

  // Read priority: in-flight commit (bypass only), then pending slot, then array.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] arr_word,
    input logic              f_en,
    input logic [ADDR_W-1:0] f_addr,
    input logic [DATA_W-1:0] f_data,
    input logic              p_valid,
    input logic [ADDR_W-1:0] p_addr,
    input logic [DATA_W-1:0] p_data
  );
    if (f_en && f_addr == a)         return f_data;
    else if (p_valid && p_addr == a) return p_data;
    else                             return arr_word;
  endfunction

  assign rd_data_a = read_port(rd_addr_a, mem[rd_addr_a], fwd_en, commit_addr,
                               commit_data, pend_valid, pend_addr, pend_data);
  assign rd_data_b = read_port(rd_addr_b, mem[rd_addr_b], fwd_en, commit_addr,
                               commit_data, pend_valid, pend_addr, pend_data);

  assign mode_flag = (fwd_en && commit_addr == MODE_ADDR)     ? commit_data[0] :
                     (pend_valid && pend_addr == MODE_ADDR)   ? pend_data[0]   :
                                                                mem[MODE_ADDR][0];

endmodule

// File: tb/tb_prg_register_bank.sv
// Bench for prg_register_bank: directed scenarios, inputs driven on the
// falling edge, outputs sampled 1ns after the rising edge (or 1ns after the
// falling-edge drive for same-cycle observations). Expected read data is
// queued when stimulus is driven and popped when the DUT output is sampled.
module tb_prg_register_bank;
  import prg_pkg::*;

  logic        clock;
  logic        reset;
  logic        PRG_write_flag;
  logic [7:0]  PRG_write_addr;
  logic [31:0] PRG_write_data;
  logic        ALU_write_flag;
  logic [7:0]  ALU_write_addr;
  logic [31:0] ALU_write_data;
  logic [7:0]  rd_addr_a;
  logic [7:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        mode_flag;
  logic        stall;
  logic        drop_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  prg_register_bank dut (
    .clock         (clock),
    .reset         (reset),
    .PRG_write_flag(PRG_write_flag),
    .PRG_write_addr(PRG_write_addr),
    .PRG_write_data(PRG_write_data),
    .ALU_write_flag(ALU_write_flag),
    .ALU_write_addr(ALU_write_addr),
    .ALU_write_data(ALU_write_data),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .mode_flag     (mode_flag),
    .stall         (stall),
    .drop_err      (drop_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- driver tasks ----------------
  function automatic prg_wr_t wr(input logic [7:0] a, input logic [31:0] d);
    prg_wr_t w;
    w.flag = 1'b1;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  localparam prg_wr_t NO_WR = '0;

  // Drive both write ports on the falling edge, then settle 1ns.
  task automatic drive(input prg_wr_t alu, input prg_wr_t pc);
    @(negedge clock);
    ALU_write_flag = alu.flag;
    ALU_write_addr = alu.addr;
    ALU_write_data = alu.data;
    PRG_write_flag = pc.flag;
    PRG_write_addr = pc.addr;
    PRG_write_data = pc.data;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    ALU_write_flag = 1'b0;
    PRG_write_flag = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rd_addr_a = 8'h00;
    rd_addr_b = 8'h24;
    #2;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL reset_rd_a00 got=%h exp=%h", rd_data_a, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL reset_rd_b24 got=%h exp=%h", rd_data_b, exp); end
    checks++;
    if (mode_flag !== 1'b0) begin failures++; $display("FAIL reset_mode got=%b exp=0", mode_flag); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    rd_addr_a = 8'hFF;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL reset_rd_aFF got=%h exp=%h", rd_data_a, exp); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_alu_write();
    rd_addr_a = 8'h10;
    drive(wr(8'h10, 32'hDEADBEEF), NO_WR);
`ifdef PRG_BYPASS_EN
    exp_q.push_back(32'hDEADBEEF);
`else
    exp_q.push_back(32'h0);
`endif
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL alu_same_cycle got=%h exp=%h", rd_data_a, exp); end
    edge_sample();
    exp_q.push_back(32'hDEADBEEF);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL alu_after_edge got=%h exp=%h", rd_data_a, exp); end
  endtask

  task automatic test_defer();
    rd_addr_a = 8'h06;
    rd_addr_b = 8'h05;
    drive(wr(8'h05, 32'h1), wr(8'h06, 32'h2));
`ifdef PRG_BYPASS_EN
    exp_q.push_back(32'h1);
`else
    exp_q.push_back(32'h0);
`endif
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL defer_pre_b got=%h exp=%h", rd_data_b, exp); end
    edge_sample();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL defer_stall1 got=%b exp=1", stall); end
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL defer_slot_rd got=%h exp=%h", rd_data_a, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL defer_alu_rd got=%h exp=%h", rd_data_b, exp); end
    drive(NO_WR, NO_WR);
    edge_sample();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL defer_stall2 got=%b exp=0", stall); end
    exp_q.push_back(32'h2);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL defer_commit_rd got=%h exp=%h", rd_data_a, exp); end
    checks++;
    if (drop_err !== 1'b0) begin failures++; $display("FAIL defer_drop got=%b exp=0", drop_err); end
  endtask

  task automatic test_back_to_back();
    rd_addr_a = 8'h07;
    rd_addr_b = 8'h09;
    drive(wr(8'h08, 32'hA1), wr(8'h07, 32'h77));
    edge_sample();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall_e1 got=%b exp=1", stall); end
    exp_q.push_back(32'h77);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL b2b_pend_rd got=%h exp=%h", rd_data_a, exp); end
    // Second PC write while stalled, different address: must be lost.
    drive(wr(8'h08, 32'hA2), wr(8'h09, 32'h99));
    edge_sample();
    checks++;
    if (drop_err !== 1'b1) begin failures++; $display("FAIL b2b_drop_set got=%b exp=1", drop_err); end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall_e2 got=%b exp=1", stall); end
    drive(wr(8'h08, 32'hA3), NO_WR);
    edge_sample();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall_e3 got=%b exp=1", stall); end
    rd_addr_b = 8'h08;
    drive(NO_WR, NO_WR);
    edge_sample();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_e4 got=%b exp=0", stall); end
    exp_q.push_back(32'h77);
    exp_q.push_back(32'hA3);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL b2b_landed_07 got=%h exp=%h", rd_data_a, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL b2b_alu_08 got=%h exp=%h", rd_data_b, exp); end
    rd_addr_b = 8'h09;
    repeat (2) edge_sample();
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL b2b_lost_09 got=%h exp=%h", rd_data_b, exp); end
    checks++;
    if (drop_err !== 1'b1) begin failures++; $display("FAIL b2b_drop_sticky got=%b exp=1", drop_err); end
  endtask

  task automatic test_mode();
    apply_reset();
    rd_addr_a = 8'h24;
    drive(wr(8'h24, 32'h0), wr(8'h24, 32'h1));
    edge_sample();
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL mode_collide_rd got=%h exp=%h", rd_data_a, exp); end
    checks++;
    if (mode_flag !== 1'b0) begin failures++; $display("FAIL mode_collide_flag got=%b exp=0", mode_flag); end
    checks++;
    if (drop_err !== 1'b0) begin failures++; $display("FAIL mode_collide_drop got=%b exp=0", drop_err); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mode_collide_stall got=%b exp=0", stall); end
    drive(NO_WR, wr(8'h24, 32'h1));
    checks++;
`ifdef PRG_BYPASS_EN
    if (mode_flag !== 1'b1) begin failures++; $display("FAIL mode_pre_edge got=%b exp=1", mode_flag); end
`else
    if (mode_flag !== 1'b0) begin failures++; $display("FAIL mode_pre_edge got=%b exp=0", mode_flag); end
`endif
    edge_sample();
    checks++;
    if (mode_flag !== 1'b1) begin failures++; $display("FAIL mode_set got=%b exp=1", mode_flag); end
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL mode_rd got=%h exp=%h", rd_data_a, exp); end
  endtask

  task automatic test_reset_mid();
    rd_addr_a = 8'h31;
    rd_addr_b = 8'h30;
    drive(wr(8'h30, 32'h5), wr(8'h31, 32'h31));
    edge_sample();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rmid_stall_pre got=%b exp=1", stall); end
    drive(NO_WR, NO_WR);
    // Asynchronous pulse between edges; released before the next rising edge.
    #1 reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall_async got=%b exp=0", stall); end
    checks++;
    if (mode_flag !== 1'b0) begin failures++; $display("FAIL rmid_mode_async got=%b exp=0", mode_flag); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL rmid_rd_a_async got=%h exp=%h", rd_data_a, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp) begin failures++; $display("FAIL rmid_rd_b_async got=%h exp=%h", rd_data_b, exp); end
    #1 reset = 1'b0;
    edge_sample();
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp) begin failures++; $display("FAIL rmid_rd_after got=%h exp=%h", rd_data_a, exp); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall_after got=%b exp=0", stall); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset          = 1'b1;
    PRG_write_flag = 1'b0;
    PRG_write_addr = '0;
    PRG_write_data = '0;
    ALU_write_flag = 1'b0;
    ALU_write_addr = '0;
    ALU_write_data = '0;
    rd_addr_a      = '0;
    rd_addr_b      = '0;
    test_reset();
    test_alu_write();
    test_defer();
    test_back_to_back();
    test_mode();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
